// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified instruction/data memory port between the IF and MEM stages.
// Optional `ARB_STATS_EN adds conflict and IF-wait counters; without it the stat ports read 0.
module mem_port_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        Reset,
    // instruction fetch requester
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    // load/store requester
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_valid,
    output logic [31:0] mem_rdata,
    // memory port
    output logic        port_en,
    output logic        port_we,
    output logic [31:0] port_addr,
    output logic [31:0] port_wdata,
    input  logic [31:0] port_rdata,
    // pipeline hold requests
    output logic        stall_if,
    output logic        stall_mem,
    // statistics
    output logic [31:0] stat_conflicts,
    output logic [31:0] stat_if_wait
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM
    } state_e;

    localparam logic [3:0] LAT_INIT = 4'(RD_LAT);
    localparam logic [3:0] FAIR_MAX = 4'(FAIR_LIMIT);

    state_e     state_q, state_d;
    logic [3:0] lat_cnt_q, lat_cnt_d;
    logic [3:0] fair_cnt_q, fair_cnt_d;

    logic complete;
    logic arb_en;
    logic grant_mem;
    logic grant_if;

    // Arbitration and next-state logic; a completing access re-arbitrates in the same cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        fair_cnt_d = fair_cnt_q;

        complete  = (state_q != IDLE) && (lat_cnt_q == 4'd1);
        arb_en    = (state_q == IDLE) || complete;
        grant_mem = arb_en && mem_req && (!if_req || (fair_cnt_q < FAIR_MAX));
        grant_if  = arb_en && !grant_mem && if_req;

        if (grant_mem) begin
            state_d   = BUSY_MEM;
            lat_cnt_d = LAT_INIT;
            if (!if_req) begin
                fair_cnt_d = 4'd0;
            end else if (fair_cnt_q < FAIR_MAX) begin
                fair_cnt_d = fair_cnt_q + 4'd1;
            end
        end else if (grant_if) begin
            state_d    = BUSY_IF;
            lat_cnt_d  = LAT_INIT;
            fair_cnt_d = 4'd0;
        end else if (complete) begin
            state_d   = IDLE;
            lat_cnt_d = 4'd0;
        end else if (state_q != IDLE) begin
            lat_cnt_d = lat_cnt_q - 4'd1;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            lat_cnt_q  <= 4'd0;
            fair_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            fair_cnt_q <= fair_cnt_d;
        end
    end

    // Outputs are forced to zero while Reset is high, even though requests may still be asserted.
    always_comb begin
        port_en    = 1'b0;
        port_we    = 1'b0;
        port_addr  = 32'd0;
        port_wdata = 32'd0;
        if_valid   = 1'b0;
        if_rdata   = 32'd0;
        mem_valid  = 1'b0;
        mem_rdata  = 32'd0;
        stall_if   = 1'b0;
        stall_mem  = 1'b0;

        if (!Reset) begin
            if (grant_mem) begin
                port_en    = 1'b1;
                port_we    = mem_we;
                port_addr  = mem_addr;
                port_wdata = mem_wdata;
            end else if (grant_if) begin
                port_en   = 1'b1;
                port_addr = if_addr;
            end

            if (complete && (state_q == BUSY_IF)) begin
                if_valid = 1'b1;
                if_rdata = port_rdata;
            end
            if (complete && (state_q == BUSY_MEM)) begin
                mem_valid = 1'b1;
                mem_rdata = port_rdata;
            end

            stall_if  = if_req && !if_valid;
            stall_mem = mem_req && !mem_valid;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] stat_conflicts_q, stat_conflicts_d;
    logic [31:0] stat_if_wait_q, stat_if_wait_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        stat_conflicts_d = stat_conflicts_q;
        stat_if_wait_d   = stat_if_wait_q;
        if (arb_en && if_req && mem_req) begin
            stat_conflicts_d = stat_conflicts_q + 32'd1;
        end
        if (stall_if) begin
            stat_if_wait_d = stat_if_wait_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            stat_conflicts_q <= 32'd0;
            stat_if_wait_q   <= 32'd0;
        end else begin
            stat_conflicts_q <= stat_conflicts_d;
            stat_if_wait_q   <= stat_if_wait_d;
        end
    end

    assign stat_conflicts = stat_conflicts_q;
    assign stat_if_wait   = stat_if_wait_q;
`else
    assign stat_conflicts = 32'd0;
    assign stat_if_wait   = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances cover RD_LAT 1/2/4 and FAIR_LIMIT 2/4.
// Instance 0: RD_LAT=1 FAIR_LIMIT=2; instance 1: RD_LAT=2 FAIR_LIMIT=4; instance 2: RD_LAT=4 FAIR_LIMIT=4.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;

    logic [2:0]  if_req, mem_req, mem_we;
    logic [2:0]  if_valid, mem_valid, port_en, port_we, stall_if, stall_mem;
    logic [31:0] if_addr    [3];
    logic [31:0] mem_addr   [3];
    logic [31:0] mem_wdata  [3];
    logic [31:0] port_rdata [3];
    logic [31:0] if_rdata   [3];
    logic [31:0] mem_rdata  [3];
    logic [31:0] port_addr  [3];
    logic [31:0] port_wdata [3];
    logic [31:0] stat_conflicts [3];
    logic [31:0] stat_if_wait   [3];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(
            .RD_LAT    (g == 0 ? 1 : (g == 1 ? 2 : 4)),
            .FAIR_LIMIT(g == 0 ? 2 : 4)
        ) u_dut (
            .clk           (clk),
            .Reset         (rst),
            .if_req        (if_req[g]),
            .if_addr       (if_addr[g]),
            .if_valid      (if_valid[g]),
            .if_rdata      (if_rdata[g]),
            .mem_req       (mem_req[g]),
            .mem_we        (mem_we[g]),
            .mem_addr      (mem_addr[g]),
            .mem_wdata     (mem_wdata[g]),
            .mem_valid     (mem_valid[g]),
            .mem_rdata     (mem_rdata[g]),
            .port_en       (port_en[g]),
            .port_we       (port_we[g]),
            .port_addr     (port_addr[g]),
            .port_wdata    (port_wdata[g]),
            .port_rdata    (port_rdata[g]),
            .stall_if      (stall_if[g]),
            .stall_mem     (stall_mem[g]),
            .stat_conflicts(stat_conflicts[g]),
            .stat_if_wait  (stat_if_wait[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    logic [31:0] fair_addr [6] = '{32'h2000, 32'h2000, 32'h1000, 32'h2000, 32'h2000, 32'h1000};
    logic        fair_mv   [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        fair_iv   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

`ifdef ARB_STATS_EN
    localparam logic [31:0] EXP_CONFLICTS = 32'd1;
    localparam logic [31:0] EXP_IF_WAIT   = 32'd4;
`else
    localparam logic [31:0] EXP_CONFLICTS = 32'd0;
    localparam logic [31:0] EXP_IF_WAIT   = 32'd0;
`endif

    initial begin
        rst     = 1'b1;
        if_req  = '0;
        mem_req = '0;
        mem_we  = '0;
        for (int i = 0; i < 3; i++) begin
            if_addr[i]    = 32'd0;
            mem_addr[i]   = 32'd0;
            mem_wdata[i]  = 32'd0;
            port_rdata[i] = 32'd0;
        end

        // ---- reset: outputs held at zero even with requests asserted ----
        #2;
        if_req[0]     = 1'b1;
        if_addr[0]    = 32'h0000_0040;
        mem_req[1]    = 1'b1;
        mem_we[1]     = 1'b1;
        mem_addr[1]   = 32'h0000_0123;
        port_rdata[0] = 32'hFFFF_FFFF;
        #2;
        check("rst_port_en0", {31'd0, port_en[0]}, 32'd0);
        check("rst_stall_if0", {31'd0, stall_if[0]}, 32'd0);
        check("rst_port_en1", {31'd0, port_en[1]}, 32'd0);
        check("rst_port_we1", {31'd0, port_we[1]}, 32'd0);
        check("rst_stall_mem1", {31'd0, stall_mem[1]}, 32'd0);
        check("rst_port_addr1", port_addr[1], 32'd0);
        check("rst_if_rdata0", if_rdata[0], 32'd0);
        check("rst_stat_conf1", stat_conflicts[1], 32'd0);
        check("rst_stat_wait0", stat_if_wait[0], 32'd0);
        if_req  = '0;
        mem_req = '0;
        mem_we  = '0;
        port_rdata[0] = 32'd0;
        tick();
        tick();
        rst = 1'b0;

        // ---- inst 0 (RD_LAT=1): single fetch, then a back-to-back fetch ----
        tick();
        if_req[0]  = 1'b1;
        if_addr[0] = 32'h0000_0040;
        settle();
        check("f1_port_en_t", {31'd0, port_en[0]}, 32'd1);
        check("f1_port_addr_t", port_addr[0], 32'h0000_0040);
        check("f1_port_we_t", {31'd0, port_we[0]}, 32'd0);
        check("f1_stall_if_t", {31'd0, stall_if[0]}, 32'd1);
        check("f1_if_valid_t", {31'd0, if_valid[0]}, 32'd0);
        tick();
        port_rdata[0] = 32'h8C01_0004;
        settle();
        check("f1_if_valid_t1", {31'd0, if_valid[0]}, 32'd1);
        check("f1_if_rdata_t1", if_rdata[0], 32'h8C01_0004);
        check("f1_mem_rdata_t1", mem_rdata[0], 32'd0);
        check("f1_stall_if_t1", {31'd0, stall_if[0]}, 32'd0);
        check("f1_reissue_t1", {31'd0, port_en[0]}, 32'd1);
        tick();
        if_req[0]     = 1'b0;
        port_rdata[0] = 32'h1234_5678;
        settle();
        check("f1_if_valid_t2", {31'd0, if_valid[0]}, 32'd1);
        check("f1_if_rdata_t2", if_rdata[0], 32'h1234_5678);
        check("f1_port_en_t2", {31'd0, port_en[0]}, 32'd0);
        tick();
        settle();
        check("f1_if_valid_t3", {31'd0, if_valid[0]}, 32'd0);
        check("f1_if_rdata_t3", if_rdata[0], 32'd0);

        // ---- inst 0 (FAIR_LIMIT=2): both requests held, grants M M I M M I ----
        tick();
        if_req[0]     = 1'b1;
        mem_req[0]    = 1'b1;
        if_addr[0]    = 32'h0000_1000;
        mem_addr[0]   = 32'h0000_2000;
        port_rdata[0] = 32'hA5A5_5A5A;
        for (int c = 0; c < 6; c++) begin
            settle();
            check($sformatf("fair_addr_%0d", c), port_addr[0], fair_addr[c]);
            check($sformatf("fair_en_%0d", c), {31'd0, port_en[0]}, 32'd1);
            check($sformatf("fair_mv_%0d", c), {31'd0, mem_valid[0]}, {31'd0, fair_mv[c]});
            check($sformatf("fair_iv_%0d", c), {31'd0, if_valid[0]}, {31'd0, fair_iv[c]});
            tick();
        end
        if_req[0]  = 1'b0;
        mem_req[0] = 1'b0;
        settle();
        check("fair_iv_6", {31'd0, if_valid[0]}, 32'd1);
        check("fair_en_6", {31'd0, port_en[0]}, 32'd0);

        // ---- inst 1 (RD_LAT=2): simultaneous load and fetch ----
        tick();
        if_req[1]   = 1'b1;
        if_addr[1]  = 32'h0000_0044;
        mem_req[1]  = 1'b1;
        mem_we[1]   = 1'b0;
        mem_addr[1] = 32'h0000_0100;
        settle();
        check("both_port_addr_t", port_addr[1], 32'h0000_0100);
        check("both_port_en_t", {31'd0, port_en[1]}, 32'd1);
        check("both_stall_if_t", {31'd0, stall_if[1]}, 32'd1);
        check("both_stall_mem_t", {31'd0, stall_mem[1]}, 32'd1);
        tick();
        settle();
        check("both_port_en_t1", {31'd0, port_en[1]}, 32'd0);
        check("both_mem_valid_t1", {31'd0, mem_valid[1]}, 32'd0);
        check("both_stall_if_t1", {31'd0, stall_if[1]}, 32'd1);
        tick();
        mem_req[1]    = 1'b0;
        port_rdata[1] = 32'h1111_2222;
        settle();
        check("both_mem_valid_t2", {31'd0, mem_valid[1]}, 32'd1);
        check("both_mem_rdata_t2", mem_rdata[1], 32'h1111_2222);
        check("both_if_rdata_t2", if_rdata[1], 32'd0);
        check("both_if_grant_t2", port_addr[1], 32'h0000_0044);
        check("both_port_we_t2", {31'd0, port_we[1]}, 32'd0);
        check("both_stall_if_t2", {31'd0, stall_if[1]}, 32'd1);
        tick();
        settle();
        check("both_stall_if_t3", {31'd0, stall_if[1]}, 32'd1);
        check("both_if_valid_t3", {31'd0, if_valid[1]}, 32'd0);
        tick();
        if_req[1]     = 1'b0;
        port_rdata[1] = 32'h3333_4444;
        settle();
        check("both_if_valid_t4", {31'd0, if_valid[1]}, 32'd1);
        check("both_if_rdata_t4", if_rdata[1], 32'h3333_4444);
        check("both_mem_valid_t4", {31'd0, mem_valid[1]}, 32'd0);
        check("both_stall_if_t4", {31'd0, stall_if[1]}, 32'd0);
        tick();
        settle();
        check("stat_conflicts", stat_conflicts[1], EXP_CONFLICTS);
        check("stat_if_wait", stat_if_wait[1], EXP_IF_WAIT);

        // ---- inst 1: store ----
        tick();
        mem_req[1]   = 1'b1;
        mem_we[1]    = 1'b1;
        mem_addr[1]  = 32'h0000_0200;
        mem_wdata[1] = 32'hDEAD_BEEF;
        settle();
        check("st_port_en_t", {31'd0, port_en[1]}, 32'd1);
        check("st_port_we_t", {31'd0, port_we[1]}, 32'd1);
        check("st_port_addr_t", port_addr[1], 32'h0000_0200);
        check("st_port_wdata_t", port_wdata[1], 32'hDEAD_BEEF);
        tick();
        settle();
        check("st_port_we_t1", {31'd0, port_we[1]}, 32'd0);
        check("st_mem_valid_t1", {31'd0, mem_valid[1]}, 32'd0);
        tick();
        mem_req[1] = 1'b0;
        mem_we[1]  = 1'b0;
        settle();
        check("st_mem_valid_t2", {31'd0, mem_valid[1]}, 32'd1);
        check("st_port_en_t2", {31'd0, port_en[1]}, 32'd0);

        // ---- inst 2 (RD_LAT=4): reset mid-flight discards the access ----
        tick();
        mem_req[2]  = 1'b1;
        mem_addr[2] = 32'h0000_0300;
        settle();
        check("rf_port_en_t", {31'd0, port_en[2]}, 32'd1);
        tick();
        tick();
        tick();
        settle();
        check("rf_stall_mem_t3", {31'd0, stall_mem[2]}, 32'd1);
        rst = 1'b1;
        #1;
        check("rf_async_stall", {31'd0, stall_mem[2]}, 32'd0);
        check("rf_async_port_en", {31'd0, port_en[2]}, 32'd0);
        check("rf_async_stat", stat_if_wait[1], 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check("rf_regrant", {31'd0, port_en[2]}, 32'd1);
        check("rf_regrant_addr", port_addr[2], 32'h0000_0300);
        check("rf_no_valid_0", {31'd0, mem_valid[2]}, 32'd0);
        for (int c = 1; c < 4; c++) begin
            tick();
            settle();
            check($sformatf("rf_no_valid_%0d", c), {31'd0, mem_valid[2]}, 32'd0);
        end
        tick();
        mem_req[2] = 1'b0;
        settle();
        check("rf_new_valid", {31'd0, mem_valid[2]}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Grants one access at a time and tracks the in-flight latency.
- Returns read data and completion pulses to the requester that owns the access.
- Generates the stall requests that feed the PC/IF_ID keep logic and the Ex_Mem/Mem_Wr hold logic.

Parameters:
- RD_LAT, 1: memory cycles from issue (port_en) to data/completion. Legal range 1..8.
- FAIR_LIMIT, 4: consecutive MEM grants allowed while IF is waiting before IF is forced through. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held until if_valid.
- if_addr  input  32  fetch address (PC).
- if_valid  output  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  output  32  fetched instruction.
- mem_req  input  1  load/store request; held until mem_valid.
- mem_we  input  1  1 = store, 0 = load.
- mem_addr  input  32  data address (ALUShift_out_Mem).
- mem_wdata  input  32  store data.
- mem_valid  output  1  one-cycle pulse: data access complete.
- mem_rdata  output  32  load data.
- port_en  output  1  issue strobe to the memory.
- port_we  output  1  write enable to the memory.
- port_addr  output  32  memory address.
- port_wdata  output  32  memory write data.
- port_rdata  input  32  memory read data, valid RD_LAT cycles after issue.
- stall_if  output  1  IF must hold (drives Keep_PC/Keep_IF_ID).
- stall_mem  output  1  MEM must hold (freezes Ex_Mem/Mem_Wr, bubbles ID_Ex).
- stat_conflicts  output  32  see Optional Feature.
- stat_if_wait  output  32  see Optional Feature.

Behaviour:
- State machine states: IDLE, BUSY_IF, BUSY_MEM.
- Registers: owner state, lat_cnt[3:0], fair_cnt[3:0].

Reset:
- State = IDLE; lat_cnt = fair_cnt = 0.
- While Reset is high, every output is 0, including stalls and stats.
- Reset during an in-flight access discards the access; no valid pulse is produced afterwards.

Arbitration (evaluated when state = IDLE, or in the completion cycle of BUSY_*):
- mem_req & (~if_req | fair_cnt < FAIR_LIMIT) -> grant MEM.
- Else if_req -> grant IF.
- Else no grant; go to or stay in IDLE.

Issue (grant cycle t):
- port_en = 1.
- port_addr/port_we/port_wdata are driven combinationally from the granted requester.
- port_we is forced to 0 for IF grants.
- port_en = 0 and port_we = 0 in every cycle with no grant; port_addr/port_wdata are don't-care then but must not toggle X.
- lat_cnt <= RD_LAT; state <= BUSY_IF or BUSY_MEM.

Busy:
- lat_cnt decrements each cycle.
- The completion cycle is the cycle in which lat_cnt == 1 at the clock, i.e. cycle t+RD_LAT.

Completion cycle:
- Owner's valid = 1; owner's rdata = port_rdata (combinational pass-through).
- The non-owner's rdata = 0. Rdata is 0 whenever its valid is 0.
- A store also pulses mem_valid; mem_rdata = port_rdata is don't-care for stores.
- Re-arbitration happens in the same cycle: back-to-back accesses with no idle gap, throughput one access per RD_LAT cycles.

Fairness:
- On a MEM grant with if_req = 1: fair_cnt++, saturating at FAIR_LIMIT.
- On an IF grant, or a MEM grant with if_req = 0: fair_cnt <= 0.

Stalls (combinational):
- stall_if = if_req & ~if_valid.
- stall_mem = mem_req & ~mem_valid.

Protocol:
- Requester signals must be stable from req assertion until valid.
- If req is dropped mid-flight (flush), the access still completes and valid still pulses; the requester ignores it.
- Both requests in the same cycle resolve to a single grant; the loser sees its stall stay high.

Optional Feature:
Macro ARB_STATS_EN.
- Defined:
  - stat_conflicts increments by 1 in every arbitration cycle where if_req & mem_req are both high.
  - stat_if_wait increments by 1 every cycle stall_if = 1.
  - Both counters wrap at 2^32 and clear on Reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Test Plan:
- RD_LAT=1, if_req only, if_addr=0x00000040, port_rdata=0x8C010004 -> port_en at t; if_valid=1 with if_rdata=0x8C010004 at t+1; stall_if=1 at t only.
- RD_LAT=2, if_req & mem_req (load, mem_addr=0x100) same cycle -> MEM granted first; mem_valid at t+2; IF granted at t+2; if_valid at t+4; stall_if high t..t+3.
- Store mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF -> port_en=1, port_we=1, port_addr=0x200, port_wdata=0xDEADBEEF at t; mem_valid pulse at t+RD_LAT.
- FAIR_LIMIT=2, RD_LAT=1, if_req and mem_req held continuously -> grant sequence MEM, MEM, IF, MEM, MEM, IF...; fair_cnt returns to 0 after each IF grant.
- Reset asserted asynchronously mid-BUSY_MEM with RD_LAT=4 at lat_cnt=2 -> outputs go 0 immediately; after release, no mem_valid pulse for the discarded access; a new mem_req is granted in the first cycle after release.
- ARB_STATS_EN defined, the 2-requester scenario above -> stat_conflicts=1, stat_if_wait=4; without the macro, both stat outputs read 0.
